// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// memory-wait freeze with timeout, plus sticky error and saturating event counters.
module hazard_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic             IF_ID_UseRs1,
  input  logic             IF_ID_UseRs2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             IF_ID_Stall,
  output logic             IF_ID_Flush,
  output logic             Control_Sig_Stall,
  output logic             pipe_freeze,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state;
  logic [7:0]       wait_cnt;
  logic             err_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic load_use;
  logic freeze;
  logic pc_write_c, if_id_stall_c, if_id_flush_c, ctrl_stall_c;

  always_comb begin
    load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
               ((IF_ID_UseRs1 && (ID_EX_Rd == IF_ID_Rs1)) ||
                (IF_ID_UseRs2 && (ID_EX_Rd == IF_ID_Rs2)));
    // In MEM_WAIT the access is already outstanding, so only dmem_ready matters.
    freeze = (state == RUN) ? (dmem_req && !dmem_ready) : !dmem_ready;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    pc_write_c    = 1'b1;
    if_id_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    ctrl_stall_c  = 1'b0;
    if (freeze) begin
      pc_write_c    = 1'b0;
      if_id_stall_c = 1'b1;
    end else if (branch_taken) begin
      if_id_flush_c = 1'b1;
      ctrl_stall_c  = 1'b1;
    end else if (load_use) begin
      pc_write_c    = 1'b0;
      if_id_stall_c = 1'b1;
      ctrl_stall_c  = 1'b1;
    end
  end

  always_comb begin
    pc_write          = rst ? 1'b1 : pc_write_c;
    IF_ID_Stall       = rst ? 1'b0 : if_id_stall_c;
    IF_ID_Flush       = rst ? 1'b0 : if_id_flush_c;
    Control_Sig_Stall = rst ? 1'b0 : ctrl_stall_c;
    pipe_freeze       = rst ? 1'b0 : freeze;
    mem_timeout_err   = rst ? 1'b0 : err_q;
    stall_cnt         = rst ? '0   : stall_q;
    flush_cnt         = rst ? '0   : flush_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      if (!pc_write_c && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (if_id_flush_c && (flush_q != '1)) flush_q <= flush_q + 1'b1;
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (!dmem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == TIMEOUT_LAST) begin
              err_q <= 1'b1;
              state <= RUN;
            end
          end else begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios then random traffic,
// every cycle compared against a cycle-level reference model of the stall rules.
module tb_hazard_stall_controller;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 6;
  localparam int          SAT         = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
  logic             IF_ID_UseRs1, IF_ID_UseRs2, ID_EX_MemRead;
  logic             branch_taken, dmem_req, dmem_ready;
  logic             pc_write, IF_ID_Stall, IF_ID_Flush, Control_Sig_Stall, pipe_freeze;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_stall_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
    .IF_ID_UseRs1(IF_ID_UseRs1), .IF_ID_UseRs2(IF_ID_UseRs2),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .IF_ID_Stall(IF_ID_Stall), .IF_ID_Flush(IF_ID_Flush),
    .Control_Sig_Stall(Control_Sig_Stall), .pipe_freeze(pipe_freeze),
    .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: is a memory access outstanding, how many wait cycles so far.
  bit m_waiting;
  int m_waited;
  bit m_err;
  int m_stalls;
  int m_flushes;
  bit e_pc, e_st, e_fl, e_css, e_pf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_expect();
    bit hazard_ld, stuck;
    hazard_ld = ID_EX_MemRead && ID_EX_Rd != 0 &&
                ((IF_ID_UseRs1 && ID_EX_Rd == IF_ID_Rs1) || (IF_ID_UseRs2 && ID_EX_Rd == IF_ID_Rs2));
    stuck = m_waiting ? !dmem_ready : (dmem_req && !dmem_ready);
    {e_pc, e_st, e_fl, e_css, e_pf} = 5'b10000;
    if (rst)               {e_pc, e_st, e_fl, e_css, e_pf} = 5'b10000;
    else if (stuck)        {e_pc, e_st, e_fl, e_css, e_pf} = 5'b01001;
    else if (branch_taken) {e_pc, e_st, e_fl, e_css, e_pf} = 5'b10110;
    else if (hazard_ld)    {e_pc, e_st, e_fl, e_css, e_pf} = 5'b01010;
  endtask

  task automatic model_advance();
    if (rst) begin
      m_waiting = 0; m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
      return;
    end
    if (!e_pc) m_stalls  = (m_stalls  < SAT) ? m_stalls + 1  : SAT;
    if (e_fl)  m_flushes = (m_flushes < SAT) ? m_flushes + 1 : SAT;
    if (m_waiting) begin
      if (dmem_ready) m_waiting = 0;
      else begin
        m_waited++;
        if (m_waited == MEM_TIMEOUT) begin m_err = 1; m_waiting = 0; end
      end
    end else if (e_pf) begin
      m_waiting = 1; m_waited = 0;
    end
  endtask

  // Inputs are set away from the edge; sample at +1, then let the edge pass.
  task automatic tick();
    #1;
    model_expect();
    chk("pc_write", pc_write, e_pc);
    chk("IF_ID_Stall", IF_ID_Stall, e_st);
    chk("IF_ID_Flush", IF_ID_Flush, e_fl);
    chk("Control_Sig_Stall", Control_Sig_Stall, e_css);
    chk("pipe_freeze", pipe_freeze, e_pf);
    chk("mem_timeout_err", mem_timeout_err, rst ? 0 : m_err);
    chk("stall_cnt", stall_cnt, rst ? 0 : m_stalls);
    chk("flush_cnt", flush_cnt, rst ? 0 : m_flushes);
    @(posedge clk);
    model_advance();
    #2;
  endtask

  task automatic idle_inputs();
    IF_ID_Rs1 = 0; IF_ID_Rs2 = 0; ID_EX_Rd = 0;
    IF_ID_UseRs1 = 0; IF_ID_UseRs2 = 0; ID_EX_MemRead = 0;
    branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // quiet pipeline
    repeat (10) tick();
    chk("quiet_stall_cnt", stall_cnt, 0);

    // load-use on rs2, then the same with rd = x0
    ID_EX_MemRead = 1; ID_EX_Rd = 5; IF_ID_Rs2 = 5; IF_ID_UseRs2 = 1;
    #1; chk("lu_bubble", {pc_write, IF_ID_Stall, Control_Sig_Stall}, 3'b011); #1;
    tick();
    ID_EX_MemRead = 0; tick();
    chk("lu_stall_cnt", stall_cnt, 1);
    ID_EX_MemRead = 1; ID_EX_Rd = 0; IF_ID_Rs2 = 0; tick();
    ID_EX_MemRead = 0; tick();
    chk("lu_x0_stall_cnt", stall_cnt, 1);

    // memory wait, ready after three low cycles
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    repeat (3) tick();
    dmem_ready = 1;
    #1; chk("mem_release_freeze", pipe_freeze, 0); #1;
    tick();
    idle_inputs(); tick();
    chk("mem_stall_cnt", stall_cnt, 3);
    chk("mem_no_err", mem_timeout_err, 0);

    // memory timeout: five frozen cycles, then sticky error
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    repeat (5) tick();
    dmem_req = 0; tick();
    chk("timeout_err", mem_timeout_err, 1);
    chk("timeout_stall_cnt", stall_cnt, 5);
    repeat (4) tick();
    chk("timeout_err_sticky", mem_timeout_err, 1);
    do_reset();
    chk("timeout_err_cleared", mem_timeout_err, 0);

    // branch beats load-use
    branch_taken = 1; ID_EX_MemRead = 1; ID_EX_Rd = 7; IF_ID_Rs1 = 7; IF_ID_UseRs1 = 1;
    #1; chk("br_lu_outputs", {pc_write, IF_ID_Flush, Control_Sig_Stall, IF_ID_Stall}, 4'b1110); #1;
    tick();
    idle_inputs(); tick();
    chk("br_lu_flush_cnt", flush_cnt, 1);
    chk("br_lu_stall_cnt", stall_cnt, 0);

    // branch held during a memory wait, acted on at release; then reset mid-wait
    do_reset();
    dmem_req = 1; dmem_ready = 0; branch_taken = 1;
    repeat (2) tick();
    dmem_ready = 1;
    #1; chk("br_release_flush", IF_ID_Flush, 1); #1;
    tick();
    idle_inputs(); tick();
    chk("br_wait_flush_cnt", flush_cnt, 1);
    dmem_req = 1; dmem_ready = 0;
    repeat (2) tick();
    rst = 1; tick();
    rst = 0; idle_inputs(); tick();
    chk("rst_mid_wait_stall", stall_cnt, 0);
    chk("rst_mid_wait_flush", flush_cnt, 0);
    chk("rst_mid_wait_freeze", pipe_freeze, 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      ID_EX_MemRead = ($urandom_range(0, 2) == 0);
      ID_EX_Rd      = 5'($urandom_range(0, 3));
      IF_ID_Rs1     = 5'($urandom_range(0, 3));
      IF_ID_Rs2     = 5'($urandom_range(0, 3));
      IF_ID_UseRs1  = 1'($urandom_range(0, 1));
      IF_ID_UseRs2  = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 5) == 0);
      dmem_req      = ($urandom_range(0, 3) == 0);
      dmem_ready    = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Observes the ID and EX stage registers, the EX branch decision and the data-memory handshake.
- Drives PC write-enable, IF/ID hold and flush, the ID/EX control bubble (Control_Sig_Stall) and a whole-pipeline freeze for slow memory.
- Keeps sticky error and saturating performance counters for stalls and flushes.

Parameters:
MEM_TIMEOUT, 16, max MEM_WAIT cycles with dmem_ready low before abandoning the wait (range 2..255)
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
IF_ID_Rs1  input  5  rs1 field of the instruction in ID
IF_ID_Rs2  input  5  rs2 field of the instruction in ID
IF_ID_UseRs1  input  1  instruction in ID reads rs1
IF_ID_UseRs2  input  1  instruction in ID reads rs2
ID_EX_MemRead  input  1  instruction in EX is a load
ID_EX_Rd  input  5  destination register of the instruction in EX
branch_taken  input  1  EX resolved a taken branch or jump this cycle
dmem_req  input  1  MEM stage has an active load or store (EX_MEM_MemRead | EX_MEM_MemWrite)
dmem_ready  input  1  data memory completes the access this cycle
pc_write  output  1  PC register load enable
IF_ID_Stall  output  1  IF/ID holds its current contents
IF_ID_Flush  output  1  IF/ID loads a bubble
Control_Sig_Stall  output  1  ID/EX control fields load zeros
pipe_freeze  output  1  all stage registers (ID/EX, EX/MEM, MEM/WB) hold
mem_timeout_err  output  1  sticky flag: a memory wait timed out
stall_cnt  output  CNT_W  cycles with pc_write=0, saturating
flush_cnt  output  CNT_W  branch flushes, saturating

Behaviour:
- FSM states: RUN, MEM_WAIT. Registered state: FSM state, 8-bit wait_cnt, mem_timeout_err, stall_cnt, flush_cnt.
- Control outputs are combinational from state and inputs. While rst=1 all outputs are forced to reset values.
- Reset values: pc_write=1, every other 1-bit output 0, counters 0, state RUN, wait_cnt 0.
- load_use is defined as: ID_EX_MemRead & (ID_EX_Rd!=0) & ((IF_ID_UseRs1 & ID_EX_Rd==IF_ID_Rs1) | (IF_ID_UseRs2 & ID_EX_Rd==IF_ID_Rs2)).
- Priority, evaluated each cycle in RUN and in the MEM_WAIT release cycle: memory stall > branch flush > load-use > normal.
- Memory stall:
  - Condition: in RUN with dmem_req=1 and dmem_ready=0.
  - Outputs: pipe_freeze=1, pc_write=0, IF_ID_Stall=1, IF_ID_Flush=0, Control_Sig_Stall=0.
  - Next state MEM_WAIT, wait_cnt<=0.
- Branch flush:
  - Outputs: IF_ID_Flush=1, Control_Sig_Stall=1, pc_write=1 (the PC takes the redirect target).
  - flush_cnt increments.
  - One cycle only; no state change.
- Load-use:
  - Outputs: pc_write=0, IF_ID_Stall=1, Control_Sig_Stall=1.
  - Exactly one bubble, because the next cycle has ID_EX_MemRead=0.
- Normal: pc_write=1, all other control outputs 0.
- MEM_WAIT with dmem_ready=0:
  - Freeze outputs as for the memory stall; wait_cnt increments.
  - If wait_cnt==MEM_TIMEOUT-1: set mem_timeout_err, next state RUN. The freeze is still asserted in that cycle.
- MEM_WAIT with dmem_ready=1 (release cycle):
  - No freeze.
  - The normal priority chain (branch, then load-use) applies in this cycle.
  - Next state RUN.
- Freeze and branch together: the freeze wins. The EX stage is frozen, so branch_taken stays stable and is acted on in the release cycle.
- Branch and load-use together: the branch wins, because the ID instruction is wrong-path. No stall cycle is counted.
- stall_cnt increments every cycle in which pc_write=0. Both counters saturate at 2^CNT_W-1.
- mem_timeout_err is cleared only by rst.
- rst asserted mid-MEM_WAIT: state RUN and all registers cleared on that edge. Outputs are at reset values during the rst cycle.

Test Plan:
- Reset then no hazards, 10 cycles → pc_write=1, all stall/flush outputs 0, stall_cnt=0.
- ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs2=5, UseRs2=1 → one cycle pc_write=0, IF_ID_Stall=1, Control_Sig_Stall=1; then normal; stall_cnt=1. Same stimulus with Rd=0 → no stall.
- dmem_req=1, dmem_ready low for 3 cycles then high → pipe_freeze=1 for 3 cycles, 0 in the ready cycle; stall_cnt=3; mem_timeout_err=0.
- dmem_req=1, dmem_ready never high, MEM_TIMEOUT=4 → freeze for 5 cycles, then mem_timeout_err=1 and state RUN; err stays 1 until rst.
- branch_taken=1 together with a load-use match → IF_ID_Flush=1, Control_Sig_Stall=1, pc_write=1; flush_cnt=1, stall_cnt unchanged.
- branch_taken=1 during MEM_WAIT, ready after 2 cycles → no flush while frozen; flush asserted in the release cycle; rst asserted during a later MEM_WAIT → RUN next cycle with counters 0.
